// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared time-field codes, field limits, ring state and time struct
// Used by alarm_channel and alarm_bank. Holds the select codes that pick the edited
// field, the wrap limits of each field, the per-channel ring state enum, the packed
// time struct and a helper that adds whole minutes to a time with hour/day wrap.
package clock_pkg;

    localparam logic [1:0] SELECT_NONE = 2'd0;
    localparam logic [1:0] SELECT_SEC  = 2'd1;
    localparam logic [1:0] SELECT_MIN  = 2'd2;
    localparam logic [1:0] SELECT_HOUR = 2'd3;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    typedef enum logic [1:0] {
        RING_IDLE    = 2'd0,
        RING_RINGING = 2'd1,
        RING_SNOOZED = 2'd2
    } ring_state_t;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } time_t;

    // Adds up to 59 minutes; at most one minute wrap, which carries into the hour.
    function automatic time_t add_minutes(input time_t t, input logic [5:0] minutes);
        time_t      r;
        logic [6:0] m_sum;
        r     = t;
        m_sum = {1'b0, t.min} + {1'b0, minutes};
        if (m_sum > {1'b0, MIN_MAX}) begin
            r.min  = 6'(m_sum - 7'd60);
            r.hour = (t.hour == HOUR_MAX) ? 5'd0 : t.hour + 5'd1;
        end else begin
            r.min = m_sum[5:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// rtl/alarm_channel.sv - one alarm channel: stored time, armed bit, ring FSM and counter
// Optional feature macro: ALARM_SNOOZE_EN (adds snooze_en input and snooze target register).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   tick                       one-cycle pulse when the running second changes
//   cur_sec/cur_min/cur_hour   running time
//   edit_en, edit_sel          increment the selected field of this channel
//   arm_en                     toggle the armed bit of this channel
//   dismiss                    silence this channel
//   snooze_en                  snooze edge (ALARM_SNOOZE_EN only)
//   sec_out/min_out/hour_out   stored alarm time
//   armed, ringing             armed bit, ring state is RINGING
module alarm_channel
    import clock_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic [4:0] cur_hour,
    input  logic       edit_en,
    input  logic [1:0] edit_sel,
    input  logic       arm_en,
    input  logic       dismiss,
`ifdef ALARM_SNOOZE_EN
    input  logic       snooze_en,
`endif
    output logic [5:0] sec_out,
    output logic [5:0] min_out,
    output logic [4:0] hour_out,
    output logic       armed,
    output logic       ringing
);

    // Counter runs 0..RING_SECONDS-1; the tick that would reach RING_SECONDS ends the ring.
    localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);

    time_t       time_q, time_d;
    logic        armed_q, armed_d;
    ring_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    time_t       cur;
    logic        match;

`ifdef ALARM_SNOOZE_EN
    localparam logic [5:0] SNOOZE_INC = 6'(SNOOZE_MINUTES);
    time_t       target_q, target_d;
`else
    logic        unused_snooze_param;
    assign unused_snooze_param = ^6'(SNOOZE_MINUTES);
`endif

    assign cur = {cur_hour, cur_min, cur_sec};

    always_comb begin
        time_d  = time_q;
        armed_d = armed_q ^ arm_en;
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef ALARM_SNOOZE_EN
        target_d = target_q;
`endif

        if (edit_en) begin
            case (edit_sel)
                SELECT_SEC:  time_d.sec  = (time_q.sec  == SEC_MAX)  ? 6'd0 : time_q.sec  + 6'd1;
                SELECT_MIN:  time_d.min  = (time_q.min  == MIN_MAX)  ? 6'd0 : time_q.min  + 6'd1;
                SELECT_HOUR: time_d.hour = (time_q.hour == HOUR_MAX) ? 5'd0 : time_q.hour + 5'd1;
                default: ;
            endcase
        end

        // Uses the pre-edit time and pre-toggle armed bit, so an arm in this cycle
        // never fires for the current second.
        match = tick && armed_q && (cur == time_q);

        case (state_q)
            RING_IDLE: begin
                if (match) begin
                    state_d = RING_RINGING;
                    cnt_d   = 8'd0;
                end
            end
            RING_RINGING: begin
`ifdef ALARM_SNOOZE_EN
                if (snooze_en) begin
                    state_d  = RING_SNOOZED;
                    target_d = add_minutes(cur, SNOOZE_INC);
                end else
`endif
                if (tick) begin
                    if (cnt_q == RING_LAST) begin
                        state_d = RING_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            RING_SNOOZED: begin
`ifdef ALARM_SNOOZE_EN
                if (tick && (cur == target_q)) begin
                    state_d = RING_RINGING;
                    cnt_d   = 8'd0;
                end
`else
                state_d = RING_IDLE;
`endif
            end
            default: state_d = RING_IDLE;
        endcase

        // Dismiss and disarm override any match or snooze return in the same cycle.
        if (dismiss || (arm_en && armed_q)) begin
            state_d = RING_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_q  <= '0;
            armed_q <= 1'b0;
            state_q <= RING_IDLE;
            cnt_q   <= 8'd0;
`ifdef ALARM_SNOOZE_EN
            target_q <= '0;
`endif
        end else begin
            time_q  <= time_d;
            armed_q <= armed_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef ALARM_SNOOZE_EN
            target_q <= target_d;
`endif
        end
    end

    assign sec_out  = time_q.sec;
    assign min_out  = time_q.min;
    assign hour_out = time_q.hour;
    assign armed    = armed_q;
    assign ringing  = (state_q == RING_RINGING);

endmodule

// File: rtl/alarm_bank.sv
// rtl/alarm_bank.sv - NUM_ALARMS-channel alarm unit with shared edge detect and second tick
// Optional feature macro: ALARM_SNOOZE_EN (adds the snooze input and per-channel snooze).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   sec_in/min_in/hour_in      running time from the clock block
//   chan                       channel addressed by edits, arm toggle and readback
//   select                     field to edit (SELECT_NONE/SEC/MIN/HOUR)
//   increment, arm_toggle      level inputs, act on their rising edge
//   dismiss                    level, silences every channel
//   snooze                     level, rising edge snoozes ringing channels (ALARM_SNOOZE_EN only)
//   sec_out/min_out/hour_out   stored time of chan (combinational readback)
//   armed, ringing             per-channel bits
//   out                        any channel ringing
module alarm_bank
    import clock_pkg::*;
#(
    parameter int  NUM_ALARMS     = 4,
    parameter int  RING_SECONDS   = 60,
    parameter int  SNOOZE_MINUTES = 5,
    localparam int CH_W           = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            sec_in,
    input  logic [5:0]            min_in,
    input  logic [4:0]            hour_in,
    input  logic [CH_W-1:0]       chan,
    input  logic [1:0]            select,
    input  logic                  increment,
    input  logic                  arm_toggle,
    input  logic                  dismiss,
`ifdef ALARM_SNOOZE_EN
    input  logic                  snooze,
`endif
    output logic [5:0]            sec_out,
    output logic [5:0]            min_out,
    output logic [4:0]            hour_out,
    output logic [NUM_ALARMS-1:0] armed,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic                  out
);

    logic       inc_q, inc_d;
    logic       arm_q, arm_d;
    logic [5:0] sec_prev_q, sec_prev_d;
    logic       tick_en_q, tick_en_d;
    logic       inc_edge, arm_edge, tick;
`ifdef ALARM_SNOOZE_EN
    logic       snz_q, snz_d;
    logic       snz_edge;
`endif

    logic [5:0] ch_sec  [NUM_ALARMS];
    logic [5:0] ch_min  [NUM_ALARMS];
    logic [4:0] ch_hour [NUM_ALARMS];

    always_comb begin
        inc_d      = increment;
        arm_d      = arm_toggle;
        sec_prev_d = sec_in;
        tick_en_d  = 1'b1;
`ifdef ALARM_SNOOZE_EN
        snz_d      = snooze;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inc_q      <= 1'b0;
            arm_q      <= 1'b0;
            sec_prev_q <= 6'd0;
            tick_en_q  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_q      <= 1'b0;
`endif
        end else begin
            inc_q      <= inc_d;
            arm_q      <= arm_d;
            sec_prev_q <= sec_prev_d;
            tick_en_q  <= tick_en_d;
`ifdef ALARM_SNOOZE_EN
            snz_q      <= snz_d;
`endif
        end
    end

    assign inc_edge = increment  & ~inc_q;
    assign arm_edge = arm_toggle & ~arm_q;
    // The second sample is 0 straight out of reset, so the first cycle is masked
    // to avoid a spurious tick when the clock is not at second 0.
    assign tick     = tick_en_q && (sec_in != sec_prev_q);
`ifdef ALARM_SNOOZE_EN
    assign snz_edge = snooze & ~snz_q;
`endif

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
        alarm_channel #(
            .RING_SECONDS  (RING_SECONDS),
            .SNOOZE_MINUTES(SNOOZE_MINUTES)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .cur_sec  (sec_in),
            .cur_min  (min_in),
            .cur_hour (hour_in),
            .edit_en  (inc_edge && (chan == CH_W'(i))),
            .edit_sel (select),
            .arm_en   (arm_edge && (chan == CH_W'(i))),
            .dismiss  (dismiss),
`ifdef ALARM_SNOOZE_EN
            .snooze_en(snz_edge),
`endif
            .sec_out  (ch_sec[i]),
            .min_out  (ch_min[i]),
            .hour_out (ch_hour[i]),
            .armed    (armed[i]),
            .ringing  (ringing[i])
        );
    end

    // An out-of-range chan matches no channel and reads back as zero.
    always_comb begin
        sec_out  = 6'd0;
        min_out  = 6'd0;
        hour_out = 5'd0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (chan == CH_W'(i)) begin
                sec_out  = ch_sec[i];
                min_out  = ch_min[i];
                hour_out = ch_hour[i];
            end
        end
    end

    assign out = |ringing;

endmodule

// File: tb/tb_alarm_bank.sv
// tb/tb_alarm_bank.sv - self-checking bench for alarm_bank (ALARM_SNOOZE_EN optional)
module tb_alarm_bank;

    localparam int NA     = 4;
    localparam int RING   = 4;
    localparam int SNZ    = 1;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNOOZE_ON = 1'b1;
`else
    localparam bit SNOOZE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [5:0]    sec_in = '0;
    logic [5:0]    min_in = '0;
    logic [4:0]    hour_in = '0;
    logic [1:0]    chan = '0;
    logic [1:0]    sel = '0;
    logic          increment = 1'b0;
    logic          arm_toggle = 1'b0;
    logic          dismiss = 1'b0;
    logic          snooze = 1'b0;
    logic [5:0]    sec_out, min_out;
    logic [4:0]    hour_out;
    logic [NA-1:0] armed, ringing;
    logic          out;

    always #5 clk = ~clk;

    alarm_bank #(
        .NUM_ALARMS    (NA),
        .RING_SECONDS  (RING),
        .SNOOZE_MINUTES(SNZ)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sec_in    (sec_in),
        .min_in    (min_in),
        .hour_in   (hour_in),
        .chan      (chan),
        .select    (sel),
        .increment (increment),
        .arm_toggle(arm_toggle),
        .dismiss   (dismiss),
`ifdef ALARM_SNOOZE_EN
        .snooze    (snooze),
`endif
        .sec_out   (sec_out),
        .min_out   (min_out),
        .hour_out  (hour_out),
        .armed     (armed),
        .ringing   (ringing),
        .out       (out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: alarm times as h/m/s, snooze target as seconds of day,
    // ring length as a count-down of remaining ticks.
    int m_h [NA];
    int m_m [NA];
    int m_s [NA];
    bit m_armed [NA];
    int m_state [NA];   // 0 quiet, 1 ringing, 2 snoozed
    int m_left [NA];
    int m_target [NA];
    bit m_inc_prev, m_arm_prev, m_snz_prev, m_tick_ok;
    int m_sec_prev;

    function automatic void model_reset();
        for (int c = 0; c < NA; c++) begin
            m_h[c] = 0; m_m[c] = 0; m_s[c] = 0;
            m_armed[c] = 0; m_state[c] = 0; m_left[c] = 0; m_target[c] = 0;
        end
        m_inc_prev = 0; m_arm_prev = 0; m_snz_prev = 0; m_tick_ok = 0; m_sec_prev = 0;
    endfunction

    function automatic void model_edge();
        int now;
        bit tk, inc_e, arm_e, snz_e;
        if (reset) begin
            model_reset();
            return;
        end
        now   = int'(hour_in) * 3600 + int'(min_in) * 60 + int'(sec_in);
        tk    = m_tick_ok && (int'(sec_in) != m_sec_prev);
        inc_e = increment && !m_inc_prev;
        arm_e = arm_toggle && !m_arm_prev;
        snz_e = SNOOZE_ON && snooze && !m_snz_prev;
        for (int c = 0; c < NA; c++) begin
            int alarm_now;
            bit mine;
            alarm_now = m_h[c] * 3600 + m_m[c] * 60 + m_s[c];
            mine = (int'(chan) == c);
            if (dismiss || (arm_e && mine && m_armed[c])) begin
                m_state[c] = 0;
            end else if (m_state[c] == 0) begin
                if (tk && m_armed[c] && now == alarm_now) begin
                    m_state[c] = 1; m_left[c] = RING;
                end
            end else if (m_state[c] == 1) begin
                if (snz_e) begin
                    m_state[c] = 2; m_target[c] = (now + 60 * SNZ) % 86400;
                end else if (tk) begin
                    m_left[c]--;
                    if (m_left[c] == 0) m_state[c] = 0;
                end
            end else if (tk && now == m_target[c]) begin
                m_state[c] = 1; m_left[c] = RING;
            end
            if (inc_e && mine) begin
                case (sel)
                    2'd1: m_s[c] = (m_s[c] + 1) % 60;
                    2'd2: m_m[c] = (m_m[c] + 1) % 60;
                    2'd3: m_h[c] = (m_h[c] + 1) % 24;
                    default: ;
                endcase
            end
            if (arm_e && mine) m_armed[c] = !m_armed[c];
        end
        m_inc_prev = increment;
        m_arm_prev = arm_toggle;
        m_snz_prev = snooze;
        m_sec_prev = int'(sec_in);
        m_tick_ok  = 1;
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void compare_model();
        int ea, er;
        ea = 0; er = 0;
        for (int c = 0; c < NA; c++) begin
            if (m_armed[c])      ea |= (1 << c);
            if (m_state[c] == 1) er |= (1 << c);
        end
        check("model armed",   int'(armed),   ea);
        check("model ringing", int'(ringing), er);
        check("model out",     int'(out),     int'(er != 0));
        check("model readback", int'({hour_out, min_out, sec_out}),
              (m_h[chan] << 12) | (m_m[chan] << 6) | m_s[chan]);
    endfunction

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic pulse_inc(input int ch, input logic [1:0] s, input int n);
        chan = 2'(ch);
        sel  = s;
        for (int k = 0; k < n; k++) begin
            increment = 1'b1; cycle();
            increment = 1'b0; cycle();
        end
    endtask

    task automatic pulse_arm(input int ch);
        chan = 2'(ch);
        arm_toggle = 1'b1; cycle();
        arm_toggle = 1'b0; cycle();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hour_in = 5'(h); min_in = 6'(m); sec_in = 6'(s);
    endtask

    typedef struct {
        int         ch;
        logic [1:0] s;
        int         pulses;
        int         exp_sec;
        int         exp_min;
        int         exp_hour;
    } edit_vec_t;

    edit_vec_t edits [9];

    initial begin
        edits[0] = '{2, 2'd3, 25, 0, 0, 1};
        edits[1] = '{2, 2'd0,  4, 0, 0, 1};
        edits[2] = '{1, 2'd1, 61, 1, 0, 0};
        edits[3] = '{1, 2'd2, 60, 1, 0, 0};
        edits[4] = '{3, 2'd2, 59, 0, 59, 0};
        edits[5] = '{3, 2'd2,  1, 0, 0, 0};
        edits[6] = '{3, 2'd3, 23, 0, 0, 23};
        edits[7] = '{3, 2'd3,  1, 0, 0, 0};
        edits[8] = '{0, 2'd1,  3, 3, 0, 0};

        model_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        check("reset armed",   int'(armed), 0);
        check("reset ringing", int'(ringing), 0);
        check("reset out",     int'(out), 0);
        check("reset readback", int'({hour_out, min_out, sec_out}), 0);
        cycle();

        // field edits with wrap
        for (int i = 0; i < 9; i++) begin
            pulse_inc(edits[i].ch, edits[i].s, edits[i].pulses);
            check($sformatf("edit%0d sec", i),  int'(sec_out),  edits[i].exp_sec);
            check($sformatf("edit%0d min", i),  int'(min_out),  edits[i].exp_min);
            check($sformatf("edit%0d hour", i), int'(hour_out), edits[i].exp_hour);
        end

        // held increment acts once
        chan = 2'd1; sel = 2'd1; increment = 1'b1;
        for (int k = 0; k < 10; k++) cycle();
        increment = 1'b0; cycle();
        check("held increment sec", int'(sec_out), 2);

        // ch0 at 00:00:03 rings for exactly RING ticks
        pulse_arm(0);
        check("arm ch0", int'(armed), 1);
        for (int s = 1; s <= 2; s++) begin
            set_time(0, 0, s); cycle(); cycle();
        end
        check("before match", int'(ringing), 0);
        set_time(0, 0, 3); cycle();
        check("ring rise", int'(ringing), 1);
        cycle();
        for (int s = 4; s <= 7; s++) begin
            set_time(0, 0, s); cycle();
            check($sformatf("ring sec%0d", s), int'(ringing[0]), (s != 7) ? 1 : 0);
            cycle();
        end

        // two channels at 00:00:02, then dismiss
        pulse_inc(0, 2'd1, 59);
        check("ch0 sec wrap to 2", int'(sec_out), 2);
        pulse_arm(1);
        check("arm ch0 ch1", int'(armed), 3);
        set_time(0, 0, 2); cycle();
        check("both ringing", int'(ringing), 3);
        check("both out", int'(out), 1);
        cycle();
        dismiss = 1'b1; cycle();
        check("dismiss out", int'(out), 0);
        dismiss = 1'b0; cycle();

        // disarm while ringing, then held arm_toggle toggles once
        set_time(0, 0, 3); cycle();
        set_time(0, 0, 2); cycle();
        check("re-ring", int'(ringing), 3);
        chan = 2'd0; arm_toggle = 1'b1; cycle();
        check("disarm ringing", int'(ringing), 2);
        check("disarm armed", int'(armed), 2);
        arm_toggle = 1'b0; cycle();
        arm_toggle = 1'b1;
        for (int k = 0; k < 10; k++) cycle();
        arm_toggle = 1'b0; cycle();
        check("held arm toggle", int'(armed), 3);
        check("held arm no ring", int'(ringing), 2);
        dismiss = 1'b1; cycle(); dismiss = 1'b0; cycle();

        // dismiss in the same cycle as a match
        set_time(0, 0, 5); cycle();
        set_time(0, 0, 2); dismiss = 1'b1; cycle();
        check("dismiss vs match", int'(ringing), 0);
        dismiss = 1'b0; cycle();
        check("dismiss vs match after", int'(ringing), 0);

        // reset mid-ring
        set_time(0, 0, 4); cycle();
        set_time(0, 0, 2); cycle();
        check("ring before reset", int'(ringing), 3);
        reset = 1'b1; cycle();
        check("reset mid-ring ringing", int'(ringing), 0);
        check("reset mid-ring armed", int'(armed), 0);
        reset = 1'b0; cycle();

`ifdef ALARM_SNOOZE_EN
        // snooze across midnight
        pulse_inc(0, 2'd3, 23);
        pulse_inc(0, 2'd2, 59);
        pulse_inc(0, 2'd1, 10);
        pulse_arm(0);
        set_time(23, 59, 9); cycle();
        set_time(23, 59, 10); cycle();
        check("snooze ring", int'(ringing), 1);
        snooze = 1'b1; cycle();
        check("snoozed silent", int'(ringing), 0);
        snooze = 1'b0; cycle();
        set_time(23, 59, 11); cycle();
        set_time(0, 0, 9); cycle();
        check("snooze before target", int'(ringing), 0);
        set_time(0, 0, 10); cycle();
        check("snooze re-ring", int'(ringing), 1);
        reset = 1'b1; cycle(); reset = 1'b0; cycle();
`endif

        // randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            int w;
            if ($urandom_range(0, 3) == 0) begin
                w = $urandom_range(0, 3);
                set_time(($urandom_range(0, 7) == 0) ? 23 : 0,
                         (w == 3) ? 59 : ((w == 2) ? 1 : 0),
                         $urandom_range(0, 7));
            end
            chan = 2'($urandom_range(0, 3));
            w = $urandom_range(0, 9);
            sel = (w < 4) ? 2'd0 : (w < 8) ? 2'd1 : (w == 8) ? 2'd2 : 2'd3;
            increment  = ($urandom_range(0, 5) == 0);
            arm_toggle = ($urandom_range(0, 7) == 0);
            dismiss    = ($urandom_range(0, 40) == 0);
            snooze     = ($urandom_range(0, 10) == 0);
            reset      = ($urandom_range(0, 250) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
